// File: rtl/crt_clock_gen_multi.sv
// Multi-channel fractional clock generator: one phase accumulator per channel,
// each producing a square clock or a one-cycle strobe at crt/sys of Clock.
module crt_clock_gen_multi #(
  parameter int FreqWidth = 10,
  parameter int Channels  = 4
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic [FreqWidth-1:0]          SystemClockFreq,
  input  logic [Channels*FreqWidth-1:0] CRTClockFreq,
  input  logic [Channels-1:0]           Mode,
  input  logic                          Load,
  output logic [Channels-1:0]           PixelClock,
  output logic [Channels-1:0]           ConfigError
);

  localparam int IncW = FreqWidth + 1;
  localparam int SumW = FreqWidth + 2;

  // Square mode advances twice as fast so that each wrap is a half period.
  function automatic logic [IncW-1:0] f_inc(input logic [FreqWidth-1:0] crt,
                                            input logic              strobe);
    f_inc = strobe ? {1'b0, crt} : {crt, 1'b0};
  endfunction

  function automatic logic f_cfg_err(input logic [FreqWidth-1:0] sys,
                                     input logic [IncW-1:0]      inc);
    f_cfg_err = (sys == '0) || (inc > {1'b0, sys});
  endfunction

  logic [FreqWidth-1:0] r_sys;
  logic [FreqWidth-1:0] r_crt  [Channels];
  logic [FreqWidth-1:0] r_acc  [Channels];
  logic [Channels-1:0]  r_mode;

  logic [IncW-1:0]      w_inc     [Channels];
  logic [SumW-1:0]      w_sum     [Channels];
  logic [FreqWidth-1:0] w_acc_nxt [Channels];
  logic [Channels-1:0]  w_wrap;
  logic [Channels-1:0]  w_idle;
  logic [Channels-1:0]  w_new_err;
  logic                 w_capture;

  assign w_capture = Reset || Load;

  always_comb begin
    for (int i = 0; i < Channels; i++) begin
      w_inc[i]     = f_inc(r_crt[i], r_mode[i]);
      w_sum[i]     = {1'b0, w_inc[i]} + {2'b0, r_acc[i]};
      w_wrap[i]    = (w_sum[i] >= {2'b0, r_sys});
      w_acc_nxt[i] = w_wrap[i] ? FreqWidth'(w_sum[i] - {2'b0, r_sys})
                               : w_sum[i][FreqWidth-1:0];
      w_idle[i]    = (r_crt[i] == '0) || ConfigError[i];
      w_new_err[i] = f_cfg_err(SystemClockFreq,
                               f_inc(CRTClockFreq[i*FreqWidth +: FreqWidth], Mode[i]));
    end
  end

  // Capture edge re-phases every channel; otherwise each channel accumulates.
  always_ff @(posedge Clock) begin
    if (w_capture) begin
      r_sys       <= SystemClockFreq;
      r_mode      <= Mode;
      PixelClock  <= '0;
      ConfigError <= w_new_err;
      for (int i = 0; i < Channels; i++) begin
        r_crt[i] <= CRTClockFreq[i*FreqWidth +: FreqWidth];
        r_acc[i] <= '0;
      end
    end else begin
      for (int i = 0; i < Channels; i++) begin
        if (w_idle[i]) begin
          r_acc[i]      <= '0;
          PixelClock[i] <= 1'b0;
        end else begin
          r_acc[i]      <= w_acc_nxt[i];
          PixelClock[i] <= r_mode[i] ? w_wrap[i] : (PixelClock[i] ^ w_wrap[i]);
        end
      end
    end
  end

endmodule
